// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state, error codes and parity helper for serial blocks
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    COMMIT
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_PARITY  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  // Nonzero result means the received parity bit disagrees with the data.
  function automatic logic parity_check(input logic data_xor, input logic par_bit,
                                        input logic odd);
    return data_xor ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/shift_capture.sv
// rtl/shift_capture.sv - enable-gated left-shift capture register with bit counter
module shift_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic             last_bit_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      data_q  <= {data_q[WIDTH-2:0], bit_i};
      count_q <= count_q + CW'(1);
    end
  end

  assign data_o     = data_q;
  // High while the next enable shifts in the final data bit.
  assign last_bit_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - serial frame FSM, parity/stop checks and valid/ready output stage
module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_tick,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sc_clr, sc_en, last_bit;
  logic [WIDTH-1:0] capture;
  logic [1:0]       err_code;

  shift_capture #(.WIDTH(WIDTH)) u_capture (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (sc_clr),
    .en_i      (sc_en),
    .bit_i     (serial_in),
    .data_o    (capture),
    .last_bit_o(last_bit)
  );

  always_comb begin
    state_d      = state_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~out_ready;
    sc_clr       = 1'b0;
    sc_en        = 1'b0;
    err_code     = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (bit_tick && !serial_in) begin
          state_d = DATA;
          sc_clr  = 1'b1;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          sc_en = 1'b1;
          if (last_bit) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          perr_d  = parity_check(^capture, serial_in, PARITY_ODD);
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          ferr_d  = ~serial_in;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        // Errors outrank an overrun; a slot freed by this cycle's handshake can take the word.
        state_d = IDLE;
        if (ferr_q)                       err_code = ERR_FRAME;
        else if (perr_q)                  err_code = ERR_PARITY;
        else if (out_valid_q && !out_ready) err_code = ERR_OVERRUN;
        else begin
          out_data_d  = capture;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_err_d  = (err_code == ERR_FRAME);
    parity_err_d = (err_code == ERR_PARITY);
    overrun_d    = (err_code == ERR_OVERRUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb/tb_serial_frame_ctrl.sv - scoreboard bench for serial_frame_ctrl
module tb_serial_frame_ctrl;

  localparam int K_WORD = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;
  localparam int K_OVR  = 3;

  logic       clk = 1'b0;
  logic       reset_n, bit_tick, serial_in, out_ready;
  logic [7:0] out_data;
  logic       out_valid, busy, parity_err, frame_err, overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  serial_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_tick  (bit_tick),
    .serial_in (serial_in),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  task automatic got(input int kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d data=%0h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        failures++;
        $display("FAIL scoreboard actual kind=%0d data=%0h expected kind=%0d data=%0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: a word is new when out_valid is seen after being low or after a handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (parity_err) got(K_PERR, 8'h00);
      if (frame_err)  got(K_FERR, 8'h00);
      if (overrun)    got(K_OVR, 8'h00);
      if (out_valid && (!prev_valid || prev_hs)) got(K_WORD, out_data);
      prev_hs    = out_valid & out_ready;
      prev_valid = out_valid;
    end
  end

  task automatic send_bit(input logic b, input int per);
    serial_in = b;
    bit_tick  = 1'b1;
    @(posedge clk);
    #1;
    bit_tick  = 1'b0;
    serial_in = 1'b1;
    if (per > 1) begin
      repeat (per - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_head(input logic [7:0] d, input logic par, input int per);
    send_bit(1'b0, per);
    for (int i = 7; i >= 0; i--) send_bit(d[i], per);
    send_bit(par, per);
  endtask

  task automatic send_frame(input logic [7:0] d, input int per);
    send_head(d, ^d, per);
    send_bit(1'b1, per);
  endtask

  initial begin
    reset_n   = 1'b0;
    bit_tick  = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {parity_err, frame_err, overrun}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 0xA5, even parity 0, latency of the output stage
    out_ready = 1'b1;
    expect_ev(K_WORD, 8'hA5);
    send_head(8'hA5, 1'b0, 4);
    send_bit(1'b1, 1);
    check("t1_commit_valid_low", out_valid, 0);
    check("t1_commit_busy", busy, 1);
    @(posedge clk);
    #1;
    check("t1_valid_rise", out_valid, 1);
    check("t1_data", out_data, 8'hA5);
    @(posedge clk);
    #1;
    check("t1_valid_consumed", out_valid, 0);
    check("t1_idle_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;

    // 2: bad parity
    expect_ev(K_PERR, 8'h00);
    send_head(8'hA5, 1'b1, 4);
    send_bit(1'b1, 4);
    check("t2_no_load", out_valid, 0);

    // 3: frame error then a good frame
    expect_ev(K_FERR, 8'h00);
    send_head(8'h3C, 1'b0, 4);
    send_bit(1'b0, 4);
    check("t3_no_load", out_valid, 0);
    expect_ev(K_WORD, 8'h81);
    send_frame(8'h81, 4);
    check("t3_data_81", out_data, 8'h81);

    // 4: overrun with consumer stalled
    out_ready = 1'b0;
    expect_ev(K_WORD, 8'h11);
    send_frame(8'h11, 4);
    expect_ev(K_OVR, 8'h00);
    send_frame(8'h22, 4);
    check("t4_held_data", out_data, 8'h11);
    check("t4_held_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t4_consumed", out_valid, 0);

    // 5: handshake in the COMMIT cycle replaces the held word
    expect_ev(K_WORD, 8'h11);
    send_frame(8'h11, 4);
    expect_ev(K_WORD, 8'h22);
    send_head(8'h22, 1'b0, 4);
    send_bit(1'b1, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t5_valid_kept", out_valid, 1);
    check("t5_data_22", out_data, 8'h22);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t5_consumed", out_valid, 0);

    // 6: asynchronous reset mid-frame, then back-to-back ticks
    expect_ev(K_WORD, 8'h11);
    send_frame(8'h11, 4);
    send_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) send_bit(i[0], 4);
    reset_n = 1'b0;
    #1;
    check("t6_reset_valid", out_valid, 0);
    check("t6_reset_data", out_data, 0);
    check("t6_reset_busy", busy, 0);
    check("t6_reset_pulses", {parity_err, frame_err, overrun}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_ev(K_WORD, 8'h5A);
    send_frame(8'h5A, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t6_data_5a", out_data, 8'h5A);
    check("t6_idle", busy, 0);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
